// File: rtl/ex_mem_stage_pkg.sv
// ============================================================================
// Module : ex_mem_stage_pkg
// Brief  : Shared widths, control-bit indices, payload and FSM types for EX/MEM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ex_mem_stage_pkg;

   localparam int XLEN   = 64;
   localparam int REG_AW = 5;
   localparam int CTRL_W = 5;

   // Bit positions inside ctrl = {reg_write, mem_read, mem_write, mem_to_reg, branch}
   localparam int CTRL_REG_WRITE = 4;
   localparam int CTRL_MEM_READ  = 3;
   localparam int CTRL_MEM_WRITE = 2;
   localparam int CTRL_MEM_TO_REG = 1;
   localparam int CTRL_BRANCH    = 0;

   typedef struct packed {
      logic [XLEN-1:0]   alu_result;
      logic              zero;
      logic [XLEN-1:0]   br_target;
      logic [XLEN-1:0]   rs2_data;
      logic [REG_AW-1:0] rd;
      logic [CTRL_W-1:0] ctrl;
   } payload_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/ex_mem_stage_if.sv
// ============================================================================
// Module : ex_mem_stage_if
// Brief  : EX-side and MEM-side valid/ready bundle of the EX/MEM stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ex_mem_stage_if;
   import ex_mem_stage_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   in_alu_result;
   logic              in_zero;
   logic [XLEN-1:0]   in_br_target;
   logic [XLEN-1:0]   in_rs2_data;
   logic [REG_AW-1:0] in_rd;
   logic [CTRL_W-1:0] in_ctrl;

   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_alu_result;
   logic [XLEN-1:0]   out_br_target;
   logic [XLEN-1:0]   out_rs2_data;
   logic [REG_AW-1:0] out_rd;
   logic [CTRL_W-1:0] out_ctrl;

   modport slave (
      input  in_valid, in_alu_result, in_zero, in_br_target, in_rs2_data, in_rd, in_ctrl,
      input  out_ready,
      output in_ready,
      output out_valid, out_alu_result, out_br_target, out_rs2_data, out_rd, out_ctrl
   );

   modport master (
      output in_valid, in_alu_result, in_zero, in_br_target, in_rs2_data, in_rd, in_ctrl,
      output out_ready,
      input  in_ready,
      input  out_valid, out_alu_result, out_br_target, out_rs2_data, out_rd, out_ctrl
   );

endinterface

`default_nettype wire

// File: rtl/ex_mem_slot.sv
// ============================================================================
// Module : ex_mem_slot
// Brief  : One payload register with load enable (main or skid slot).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_mem_slot
   import ex_mem_stage_pkg::*;
(
   input  wire logic     clk,
   input  wire logic     reset,
   input  wire logic     i_load,
   input  wire payload_t i_d,
   output payload_t      o_q
);

   payload_t r_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module : ex_mem_stage
// Brief  : EX->MEM pipeline stage, 2-entry skid buffer, branch pc_src output.
//          Optional stall counter enabled by defining EX_MEM_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage
   import ex_mem_stage_pkg::*;
`ifdef EX_MEM_STATS_EN
#(
   parameter int CNT_W = 32
)
`endif
(
   input  wire logic     clk,
   input  wire logic     reset,
   input  wire logic     i_flush,
   ex_mem_stage_if.slave bus,
   output logic          o_pc_src
`ifdef EX_MEM_STATS_EN
   ,
   output logic [CNT_W-1:0] o_stall_count
`endif
);

   state_t   r_state;
   logic     r_in_ready;
   payload_t w_in_beat;
   payload_t w_main_d;
   payload_t w_main_q;
   payload_t w_skid_q;
   logic     w_main_load;
   logic     w_skid_load;
   logic     w_accept;
   logic     w_drain;
   logic     w_out_valid;

   assign w_in_beat.alu_result = bus.in_alu_result;
   assign w_in_beat.zero       = bus.in_zero;
   assign w_in_beat.br_target  = bus.in_br_target;
   assign w_in_beat.rs2_data   = bus.in_rs2_data;
   assign w_in_beat.rd         = bus.in_rd;
   assign w_in_beat.ctrl       = bus.in_ctrl;

   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_accept    = bus.in_valid & r_in_ready;
   assign w_drain     = w_out_valid & bus.out_ready;

   // Flush discards the incoming beat, so no slot loads during it.
   always_comb begin
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
      w_main_d    = w_in_beat;
      if (!i_flush) begin
         case (r_state)
            ST_EMPTY: w_main_load = w_accept;
            ST_ONE: begin
               w_main_load = w_accept & w_drain;
               w_skid_load = w_accept & ~w_drain;
            end
            ST_FULL: begin
               w_main_load = w_drain;
               w_main_d    = w_skid_q;
            end
            default: begin
               w_main_load = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b0;
      end else if (i_flush) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               r_in_ready <= 1'b1;
               if (w_accept) r_state <= ST_ONE;
            end
            ST_ONE: begin
               if (w_accept && !w_drain) begin
                  r_state    <= ST_FULL;
                  r_in_ready <= 1'b0;
               end else begin
                  r_in_ready <= 1'b1;
                  if (!w_accept && w_drain) r_state <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_drain) begin
                  r_state    <= ST_ONE;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state    <= ST_EMPTY;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   ex_mem_slot u_main (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_main_load),
      .i_d    (w_main_d),
      .o_q    (w_main_q)
   );

   ex_mem_slot u_skid (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_skid_load),
      .i_d    (w_in_beat),
      .o_q    (w_skid_q)
   );

   assign bus.in_ready       = r_in_ready;
   assign bus.out_valid      = w_out_valid;
   assign bus.out_alu_result = w_main_q.alu_result;
   assign bus.out_br_target  = w_main_q.br_target;
   assign bus.out_rs2_data   = w_main_q.rs2_data;
   assign bus.out_rd         = w_main_q.rd;
   // Gating ctrl keeps a stale main slot from looking like a live store or writeback.
   assign bus.out_ctrl       = w_main_q.ctrl & {CTRL_W{w_out_valid}};
   assign o_pc_src           = w_out_valid & w_main_q.ctrl[CTRL_BRANCH] & w_main_q.zero;

`ifdef EX_MEM_STATS_EN
   logic [CNT_W-1:0] r_stall_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_count <= '0;
      end else if (w_out_valid && !bus.out_ready && !(&r_stall_count)) begin
         r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// Module : tb_ex_mem_stage
// Brief  : Self-checking bench for ex_mem_stage (vector table + scoreboard).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;

`ifdef EX_MEM_STATS_EN
   localparam int CNT_W = 4;
`endif

   logic clk;
   logic reset;
   logic flush;
   logic pc_src;
`ifdef EX_MEM_STATS_EN
   logic [CNT_W-1:0] stall_count;
`endif

   ex_mem_stage_if bus ();

`ifdef EX_MEM_STATS_EN
   ex_mem_stage #(.CNT_W(CNT_W)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .i_flush       (flush),
      .bus           (bus),
      .o_pc_src      (pc_src),
      .o_stall_count (stall_count)
   );
`else
   ex_mem_stage u_dut (
      .clk      (clk),
      .reset    (reset),
      .i_flush  (flush),
      .bus      (bus),
      .o_pc_src (pc_src)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] alu;
      logic        zero;
      logic [63:0] br;
      logic [63:0] rs2;
      logic [4:0]  rd;
      logic [4:0]  ctrl;
      logic        exp_pc;
   } vec_t;

   typedef struct {
      logic [63:0] alu;
      logic [63:0] br;
      logic [63:0] rs2;
      logic [4:0]  rd;
      logic [4:0]  ctrl;
      logic        pc;
   } exp_t;

   vec_t tab[6];
   exp_t sbq[$];
   exp_t e;
   int   n_vec;
   int   n_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Scoreboard: pop/compare on drain, then drop held beats on flush or push on accept.
   task automatic monitor();
      if (reset) begin
         sbq.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            n_vec++;
            if (sbq.size() == 0) begin
               n_err++;
               $display("FAIL drain_unexpected: got alu 0x%0h, expected no beat", bus.out_alu_result);
            end else begin
               e = sbq.pop_front();
               if ({bus.out_alu_result, bus.out_br_target, bus.out_rs2_data, bus.out_rd, bus.out_ctrl, pc_src}
                   !== {e.alu, e.br, e.rs2, e.rd, e.ctrl, e.pc}) begin
                  n_err++;
                  $display("FAIL drain: got alu 0x%0h br 0x%0h rs2 0x%0h rd %0d ctrl %b pc %b, expected alu 0x%0h br 0x%0h rs2 0x%0h rd %0d ctrl %b pc %b",
                           bus.out_alu_result, bus.out_br_target, bus.out_rs2_data, bus.out_rd, bus.out_ctrl, pc_src,
                           e.alu, e.br, e.rs2, e.rd, e.ctrl, e.pc);
               end
            end
         end
         if (flush) begin
            sbq.delete();
         end else if (bus.in_valid && bus.in_ready) begin
            e.alu  = bus.in_alu_result;
            e.br   = bus.in_br_target;
            e.rs2  = bus.in_rs2_data;
            e.rd   = bus.in_rd;
            e.ctrl = bus.in_ctrl;
            e.pc   = bus.in_ctrl[0] & bus.in_zero;
            sbq.push_back(e);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] alu, input logic zero, input logic [63:0] br,
                        input logic [63:0] rs2, input logic [4:0] rd, input logic [4:0] ctrl);
      bus.in_valid      = 1'b1;
      bus.in_alu_result = alu;
      bus.in_zero       = zero;
      bus.in_br_target  = br;
      bus.in_rs2_data   = rs2;
      bus.in_rd         = rd;
      bus.in_ctrl       = ctrl;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      tab[0] = '{64'h10, 1'b0, 64'h100, 64'h1111, 5'd1, 5'b10000, 1'b0};
      tab[1] = '{64'h20, 1'b1, 64'h200, 64'h2222, 5'd2, 5'b10000, 1'b0};
      tab[2] = '{64'h30, 1'b0, 64'h300, 64'h3333, 5'd3, 5'b00001, 1'b0};
      tab[3] = '{64'h0, 1'b1, 64'h8000_0040, 64'h4444, 5'd0, 5'b00001, 1'b1};
      tab[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_CAFE_F00D, 5'd31, 5'b00100, 1'b0};
      tab[5] = '{64'h8000_0000_0000_0000, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h5555, 5'd17, 5'b11111, 1'b1};

      reset = 1'b1;
      flush = 1'b0;
      bus.out_ready = 1'b0;
      drive(64'h0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd0);
      idle();
      #3;
      step();
      step();
      check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_pc_src", {63'd0, pc_src}, 64'd0);
      check("rst_out_ctrl", {59'd0, bus.out_ctrl}, 64'd0);
      check("rst_out_alu", bus.out_alu_result, 64'd0);
      reset = 1'b0;
      step();
      check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // Streaming table with MEM always ready: one-cycle latency, in_ready stays high.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(tab[i].alu, tab[i].zero, tab[i].br, tab[i].rs2, tab[i].rd, tab[i].ctrl);
         step();
         check("stream_valid", {63'd0, bus.out_valid}, 64'd1);
         check("stream_alu", bus.out_alu_result, tab[i].alu);
         check("stream_pc_src", {63'd0, pc_src}, {63'd0, tab[i].exp_pc});
         check("stream_in_ready", {63'd0, bus.in_ready}, 64'd1);
      end
      idle();
      step();
      check("stream_empty", {63'd0, bus.out_valid}, 64'd0);

      // Back-pressure: A in main, B in skid, C held upstream.
      bus.out_ready = 1'b0;
      drive(64'hA, 1'b0, 64'hA0, 64'hA00, 5'd10, 5'b10000);
      step();
      drive(64'hB, 1'b0, 64'hB0, 64'hB00, 5'd11, 5'b10000);
      step();
      drive(64'hC, 1'b0, 64'hC0, 64'hC00, 5'd12, 5'b10000);
      check("bp_full_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("bp_main_A", bus.out_alu_result, 64'hA);
      step();
      check("bp_hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("bp_hold_A", bus.out_alu_result, 64'hA);
      check("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
      bus.out_ready = 1'b1;
      step();
      check("bp_out_B", bus.out_alu_result, 64'hB);
      step();
      check("bp_out_C", bus.out_alu_result, 64'hC);
      idle();
      step();
      check("bp_drained", {63'd0, bus.out_valid}, 64'd0);

      // Branch taken / not taken.
      drive(64'h0, 1'b1, 64'h8000_0040, 64'h0, 5'd0, 5'b00001);
      step();
      check("br_taken_pc_src", {63'd0, pc_src}, 64'd1);
      check("br_target", bus.out_br_target, 64'h8000_0040);
      drive(64'h0, 1'b0, 64'h8000_0040, 64'h0, 5'd0, 5'b00001);
      step();
      check("br_not_taken_pc_src", {63'd0, pc_src}, 64'd0);
      check("br_not_taken_valid", {63'd0, bus.out_valid}, 64'd1);
      idle();
      step();
      check("br_idle_pc_src", {63'd0, pc_src}, 64'd0);

      // Flush while FULL with a beat offered.
      bus.out_ready = 1'b0;
      drive(64'hD, 1'b0, 64'h0, 64'hD00, 5'd4, 5'b00100);
      step();
      drive(64'hE, 1'b0, 64'h0, 64'hE00, 5'd5, 5'b00100);
      step();
      drive(64'hF, 1'b1, 64'h0, 64'hF00, 5'd6, 5'b00101);
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle();
      check("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("flush_out_ctrl", {59'd0, bus.out_ctrl}, 64'd0);
      check("flush_pc_src", {63'd0, pc_src}, 64'd0);
      bus.out_ready = 1'b1;
      step();
      check("flush_no_ghost", {63'd0, bus.out_valid}, 64'd0);

      // Flush with a same-cycle drain: the draining beat still completes.
      drive(64'h6A, 1'b0, 64'h0, 64'h0, 5'd7, 5'b10000);
      step();
      drive(64'h6B, 1'b0, 64'h0, 64'h0, 5'd8, 5'b10000);
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle();
      check("flush_drain_empty", {63'd0, bus.out_valid}, 64'd0);

      // Reset mid-stream with two beats held.
      bus.out_ready = 1'b0;
      drive(64'h11, 1'b1, 64'h44, 64'h0, 5'd9, 5'b00001);
      step();
      drive(64'h12, 1'b0, 64'h0, 64'h0, 5'd9, 5'b10000);
      step();
      idle();
      check("pre_rst_pc_src", {63'd0, pc_src}, 64'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("mid_rst_pc_src", {63'd0, pc_src}, 64'd0);
      check("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
      step();
      check("mid_rst_in_ready_hold", {63'd0, bus.in_ready}, 64'd0);
      reset = 1'b0;
      step();
      check("mid_rst_release_in_ready", {63'd0, bus.in_ready}, 64'd1);
      check("mid_rst_release_valid", {63'd0, bus.out_valid}, 64'd0);

`ifdef EX_MEM_STATS_EN
      check("stat_reset_value", {60'd0, stall_count}, 64'd0);
      drive(64'h77, 1'b0, 64'h0, 64'h0, 5'd3, 5'b10000);
      step();
      idle();
      repeat (7) step();
      check("stat_seven", {60'd0, stall_count}, 64'd7);
      repeat (20) step();
      check("stat_saturate", {60'd0, stall_count}, 64'd15);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("stat_flush_keeps", {60'd0, stall_count}, 64'd15);
      bus.out_ready = 1'b1;
      step();
`endif

      bus.out_ready = 1'b1;
      step();
      check("sb_empty", sbq.size(), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
